// File: rtl/fp_pkg.sv
// Shared definitions for the iterative floating-point units: flag bit positions,
// multiplier state encoding and canonical special-value builders.
package fp_pkg;

  localparam int FLAG_OVF   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 0;

  // Widest operand the helpers can build; callers size-cast down to their own width.
  localparam int MAX_FW = 64;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    NORM,
    PACK,
    DONE
  } fpmul_state_t;

  function automatic logic [MAX_FW-1:0] qnan(input int expW, input int manW);
    logic [MAX_FW-1:0] bits;
    bits = ((MAX_FW'(1) << expW) - MAX_FW'(1)) << manW;
    bits = bits | (MAX_FW'(1) << (manW - 1));
    return bits;
  endfunction

  function automatic logic [MAX_FW-1:0] inf(input logic sign, input int expW, input int manW);
    logic [MAX_FW-1:0] bits;
    bits = ((MAX_FW'(1) << expW) - MAX_FW'(1)) << manW;
    bits = bits | (MAX_FW'(sign) << (expW + manW));
    return bits;
  endfunction

endpackage

// File: rtl/fp_normalize.sv
// Combinational leading-one normaliser: counts leading zeros of value, left-aligns it and
// splits the bits below the leading one into fraction, guard and sticky.
module fp_normalize
  import fp_pkg::*;
#(
  parameter int IN_W   = 22,
  parameter int FRAC_W = 10,
  parameter int LZ_W   = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]   value,
  output logic [LZ_W-1:0]   lzCount,
  output logic [FRAC_W-1:0] frac,
  output logic              guard,
  output logic              sticky
);

  logic [IN_W-2:0] tail;

  // Ascending scan so the highest set bit has the final say.
  always_comb begin
    lzCount = LZ_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (value[i]) lzCount = LZ_W'(IN_W - 1 - i);
    end
  end

  // The size cast drops the leading one itself, leaving only the bits beneath it.
  assign tail   = (IN_W-1)'(value << lzCount);
  assign frac   = tail[IN_W-2 -: FRAC_W];
  assign guard  = tail[IN_W-2-FRAC_W];
  assign sticky = |tail[IN_W-3-FRAC_W:0];

endmodule

// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754 multiplier: shift-add mantissa product, one bit per cycle, valid/ready on both sides.
// Define FP_MUL_RNE_EN for round-to-nearest-even; the default build truncates.
module fp_mul_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int FW    = 1 + EXP_W + MAN_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] result,
  output logic [3:0]    flags
);

  localparam int MW1  = MAN_W + 1;
  localparam int PW   = 2 * MW1;
  localparam int EW   = EXP_W + 3;
  localparam int CW   = $clog2(MAN_W + 2);
  localparam int LW   = $clog2(PW + 1);
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_MAX  = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [MAX_FW-1:0] QNAN_BITS = qnan(EXP_W, MAN_W);

  fpmul_state_t state, stateNext;

  logic [EXP_W-1:0] expA, expB, effExpA, effExpB;
  logic [MAN_W-1:0] fracA, fracB;
  logic [MW1-1:0]   manA, manB;
  logic             nanA, nanB, infA, infB, zeroA, zeroB, prodSign, isSpecial;
  logic signed [EW-1:0] expSum;
  logic [FW-1:0]    specialRes;
  logic [3:0]       specialFlags;

  logic                 signReg;
  logic signed [EW-1:0] expAcc;
  logic [PW-1:0]        mcand, acc;
  logic [MW1-1:0]       mplier;
  logic [CW-1:0]        iterCnt;
  logic [MAN_W-1:0]     fracNorm;

  logic [LW-1:0]    lzCount;
  logic [MAN_W-1:0] normFrac;
  logic             normGuard, normSticky;

  logic [MAN_W-1:0]     fracFinal;
  logic signed [EW-1:0] expFinal;
  logic [FW-1:0]        packRes;
  logic [3:0]           packFlags;

`ifdef FP_MUL_RNE_EN
  logic           guardReg, stickyReg;
  logic [MAN_W:0] fracRnd;
`else
  logic unusedRoundBits;
  assign unusedRoundBits = normGuard | normSticky;
`endif

  assign expA     = a[FW-2 -: EXP_W];
  assign expB     = b[FW-2 -: EXP_W];
  assign fracA    = a[MAN_W-1:0];
  assign fracB    = b[MAN_W-1:0];
  assign nanA     = (&expA) && (fracA != '0);
  assign nanB     = (&expB) && (fracB != '0);
  assign infA     = (&expA) && (fracA == '0);
  assign infB     = (&expB) && (fracB == '0);
  assign zeroA    = (expA == '0) && (fracA == '0);
  assign zeroB    = (expB == '0) && (fracB == '0);
  assign prodSign = a[FW-1] ^ b[FW-1];

  // Subnormals carry no implicit one but sit at the same scale as exponent 1.
  assign effExpA = (expA == '0) ? EXP_W'(1) : expA;
  assign effExpB = (expB == '0) ? EXP_W'(1) : expB;
  assign manA    = {expA != '0, fracA};
  assign manB    = {expB != '0, fracB};
  assign expSum  = EW'(effExpA) + EW'(effExpB) - E_BIAS;

  always_comb begin
    isSpecial    = 1'b1;
    specialRes   = QNAN_BITS[FW-1:0];
    specialFlags = '0;
    if (nanA || nanB || (infA && zeroB) || (infB && zeroA)) begin
      specialRes = QNAN_BITS[FW-1:0];
    end else if (infA || infB) begin
      specialRes             = FW'(inf(prodSign, EXP_W, MAN_W));
      specialFlags[FLAG_OVF] = 1'b1;
      specialFlags[FLAG_NEG] = prodSign;
    end else if (zeroA || zeroB) begin
      specialRes              = {prodSign, {(FW-1){1'b0}}};
      specialFlags[FLAG_ZERO] = 1'b1;
      specialFlags[FLAG_NEG]  = prodSign;
    end else begin
      isSpecial = 1'b0;
    end
  end

  fp_normalize #(
    .IN_W  (PW),
    .FRAC_W(MAN_W),
    .LZ_W  (LW)
  ) uNormalize (
    .value  (acc),
    .lzCount(lzCount),
    .frac   (normFrac),
    .guard  (normGuard),
    .sticky (normSticky)
  );

  always_comb begin
`ifdef FP_MUL_RNE_EN
    fracRnd   = {1'b0, fracNorm} + (MAN_W+1)'(guardReg & (stickyReg | fracNorm[0]));
    fracFinal = fracRnd[MAN_W-1:0];
    expFinal  = fracRnd[MAN_W] ? expAcc + E_ONE : expAcc;
`else
    fracFinal = fracNorm;
    expFinal  = expAcc;
`endif
    packFlags           = '0;
    packFlags[FLAG_NEG] = signReg;
    if (expFinal >= E_MAX) begin
      packRes             = FW'(inf(signReg, EXP_W, MAN_W));
      packFlags[FLAG_OVF] = 1'b1;
    end else if (expFinal <= E_ZERO) begin
      packRes              = {signReg, {(FW-1){1'b0}}};
      packFlags[FLAG_ZERO] = 1'b1;
    end else begin
      packRes = {signReg, expFinal[EXP_W-1:0], fracFinal};
    end
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = isSpecial ? DONE : MUL;
      end
      MUL:  if (iterCnt == CW'(MAN_W)) stateNext = NORM;
      NORM: stateNext = PACK;
      PACK: stateNext = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      flags  <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (in_valid) begin
            signReg <= prodSign;
            expAcc  <= expSum;
            mcand   <= PW'(manA);
            mplier  <= manB;
            acc     <= '0;
            iterCnt <= '0;
            if (isSpecial) begin
              result <= specialRes;
              flags  <= specialFlags;
            end
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          iterCnt <= iterCnt + CW'(1);
        end
        NORM: begin
          // A zero count means the product reached [2,4), hence the +1.
          expAcc   <= expAcc + E_ONE - EW'(lzCount);
          fracNorm <= normFrac;
`ifdef FP_MUL_RNE_EN
          guardReg  <= normGuard;
          stickyReg <= normSticky;
`endif
        end
        PACK: begin
          result <= packRes;
          flags  <= packFlags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter at half precision: directed corner cases, handshake and reset
// checks, then random operands against an exact-arithmetic reference.
module tb_fp_mul_iter;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int FW    = 16;
  localparam int NORMAL_LAT = MAN_W + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] a;
  logic [FW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] result;
  logic [3:0]    flags;

  int total = 0;
  int bad   = 0;

  fp_mul_iter #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Exact product of the decoded values, rounded from the discarded remainder.
  function automatic logic [19:0] refMul(input logic [15:0] x, input logic [15:0] y);
    int     ex, ey, msb, e, sh;
    longint mx, my, p, frac;
    logic   s;
    bit     nanX, nanY, infX, infY, zX, zY, up;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    mx = longint'(x[9:0]);
    my = longint'(y[9:0]);
    s  = x[15] ^ y[15];
    nanX = (ex == 31) && (mx != 0);
    nanY = (ey == 31) && (my != 0);
    infX = (ex == 31) && (mx == 0);
    infY = (ey == 31) && (my == 0);
    zX   = (ex == 0) && (mx == 0);
    zY   = (ey == 0) && (my == 0);
    if (nanX || nanY || (infX && zY) || (infY && zX)) return {16'h7E00, 4'b0000};
    if (infX || infY) return {s, 15'h7C00, 3'b100, s};
    if (zX || zY) return {s, 15'h0000, 3'b010, s};
    if (ex == 0) ex = 1; else mx = mx + 1024;
    if (ey == 0) ey = 1; else my = my + 1024;
    p   = mx * my;
    msb = 0;
    for (int i = 0; i < 24; i++) if (p[i]) msb = i;
    // Product scale is 2^(ex+ey-30-20); biased exponent of the leading one:
    e  = msb - 20 + ex + ey - 15;
    up = 1'b0;
    if (msb > 10) begin
      sh   = msb - 10;
      frac = (p >> sh) & 1023;
`ifdef FP_MUL_RNE_EN
      begin
        longint rem, half;
        rem  = p & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        up   = (rem > half) || ((rem == half) && frac[0]);
      end
`endif
    end else begin
      frac = (p << (10 - msb)) & 1023;
    end
    if (up) begin
      frac = frac + 1;
      if (frac == 1024) begin
        frac = 0;
        e    = e + 1;
      end
    end
    if (e >= 31) return {s, 15'h7C00, 3'b100, s};
    if (e <= 0) return {s, 15'h0000, 3'b010, s};
    return {s, 5'(e), 10'(frac), 3'b000, s};
  endfunction

  function automatic bit isSpecialOp(input logic [15:0] x, input logic [15:0] y);
    return (x[14:10] == 5'h1F) || (y[14:10] == 5'h1F) || (x[14:0] == '0) || (y[14:0] == '0);
  endfunction

  function automatic logic [15:0] genOp();
    int         sel;
    logic [4:0] e;
    logic [9:0] f;
    sel = int'($urandom_range(0, 9));
    f   = 10'($urandom);
    case (sel)
      0: begin e = 5'd0;  if ($urandom_range(0, 1) == 0) f = '0; end
      1: begin e = 5'd31; if ($urandom_range(0, 1) == 0) f = '0; end
      2: e = 5'($urandom_range(0, 31));
      default: e = 5'($urandom_range(8, 22));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Latency counts clock edges after the accept edge until out_valid is seen.
  task automatic runOp(input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] res, output logic [3:0] fl, output int lat);
    @(negedge clk);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    fl  = flags;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic doCase(input logic [15:0] x, input logic [15:0] y, input logic [15:0] wantRes,
                        input logic [3:0] wantFlags, input int wantLat, input string tag);
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    runOp(x, y, r, f, lat);
    check({tag, "_lat"}, 32'(lat), 32'(wantLat));
    check({tag, "_res"}, 32'(r), 32'(wantRes));
    check({tag, "_flags"}, 32'(f), 32'(wantFlags));
    releaseResult();
  endtask

  initial begin
    logic [15:0] x, y, r;
    logic [19:0] want;
    logic [3:0]  f;
    int          lat, rises;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);

    doCase(16'h4000, 16'h4200, 16'h4600, 4'b0000, NORMAL_LAT, "two_x_three");
    doCase(16'hBE00, 16'h4000, 16'hC200, 4'b0001, NORMAL_LAT, "neg_product");
    doCase(16'h7BFF, 16'h4000, 16'h7C00, 4'b1000, NORMAL_LAT, "overflow");
    // Specials are already in DONE in the cycle right after the accept edge.
    doCase(16'h7C00, 16'h0000, 16'h7E00, 4'b0000, 0, "inf_x_zero");
    doCase(16'h7C01, 16'h3C00, 16'h7E00, 4'b0000, 0, "nan_in");
    doCase(16'hFC00, 16'h4000, 16'hFC00, 4'b1001, 0, "neg_inf");
    doCase(16'h8000, 16'h4000, 16'h8000, 4'b0101, 0, "neg_zero");
    doCase(16'h0400, 16'h0400, 16'h0000, 4'b0100, NORMAL_LAT, "underflow");
    doCase(16'h0001, 16'h7800, 16'h1800, 4'b0000, NORMAL_LAT, "subnormal_in");
`ifdef FP_MUL_RNE_EN
    doCase(16'h3DFF, 16'h3DFF, 16'h407F, 4'b0000, NORMAL_LAT, "round");
`else
    doCase(16'h3DFF, 16'h3DFF, 16'h407E, 4'b0000, NORMAL_LAT, "round");
`endif

    // Result must stay parked in DONE while the consumer stalls.
    runOp(16'h4000, 16'h4200, r, f, lat);
    check("stall_lat", 32'(lat), 32'(NORMAL_LAT));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_result", 32'(result), 32'h4600);
      check("stall_flags", 32'(flags), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Reset four cycles into MUL: no output may ever appear for that operation.
    @(negedge clk);
    a        = 16'h4000;
    b        = 16'h4200;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_flags", 32'(flags), 32'd0);
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check("abort_no_output", 32'(rises), 32'd0);
    doCase(16'hBE00, 16'h4000, 16'hC200, 4'b0001, NORMAL_LAT, "after_abort");

    for (int i = 0; i < 60; i++) begin
      x    = genOp();
      y    = genOp();
      want = refMul(x, y);
      doCase(x, y, want[19:4], want[3:0], isSpecialOp(x, y) ? 0 : NORMAL_LAT, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
